uc_multiciclo: RTL



---
 rtl/uc_multiciclo_if.sv | 38 +++
 rtl/uc_multiciclo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo_if.sv
// Control-side bundle between uc_multiciclo and the RV64I datapath/memory.
// Memory handshake: the unit holds mem_le or mem_escreve high for as long as it
// wants a transfer, and the transfer completes on the rising edge where the
// request and mem_pronta are both 1. mem_pronta is ignored when no request is up.
interface uc_multiciclo_if;
    logic [31:0] instrucao;
    logic        mem_pronta;
    logic        flag_igual;
    logic        flag_menor;
    logic        flag_maior_igual_u;

    logic [1:0]  soma_ou_subtrai;
    logic        usa_imm;
    logic        mem_le;
    logic        mem_escreve;
    logic        end_pc;
    logic        escreve_ri;
    logic        escreve_reg;
    logic        sel_mem;
    logic        carrega_pc;
    logic        desvio;
    logic        erro;

    // Debug view of the control FSM state encoding.
    logic [2:0]  estado;

    modport master (
        input  instrucao, mem_pronta, flag_igual, flag_menor, flag_maior_igual_u,
        output soma_ou_subtrai, usa_imm, mem_le, mem_escreve, end_pc, escreve_ri,
               escreve_reg, sel_mem, carrega_pc, desvio, erro, estado
    );

    modport slave (
        output instrucao, mem_pronta, flag_igual, flag_menor, flag_maior_igual_u,
        input  soma_ou_subtrai, usa_imm, mem_le, mem_escreve, end_pc, escreve_ri,
               escreve_reg, sel_mem, carrega_pc, desvio, erro, estado
    );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the RV64I datapath. Fetches and latches the
// instruction fields, decodes them, sequences ULA/memory/register-file/PC
// enables and resolves conditional branches from the ULA comparison flags.
module uc_multiciclo #(
    parameter int BITS          = 64,
    parameter int LIMITE_ESPERA = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    uc_multiciclo_if.master bus
);

    typedef enum logic [2:0] {
        INICIO     = 3'd0,
        BUSCA      = 3'd1,
        DECODIFICA = 3'd2,
        EXECUTA    = 3'd3,
        MEMORIA    = 3'd4,
        ESCRITA    = 3'd5,
        ERRO       = 3'd6
    } estado_t;

    typedef enum logic [2:0] {
        C_ADD    = 3'd0,
        C_SUB    = 3'd1,
        C_ADDI   = 3'd2,
        C_LD     = 3'd3,
        C_SD     = 3'd4,
        C_BR     = 3'd5,
        C_ILEGAL = 3'd6
    } classe_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [7:0] LIMITE    = 8'(LIMITE_ESPERA);

    estado_t    estado;
    classe_t    classe;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [7:0] espera;
    logic [7:0] espera_prox;
    logic       tomado;

    // Only opcode, funct3 and funct7 matter here; register and immediate
    // fields belong to the datapath. BITS is kept for uniform instantiation.
    logic unused_campos;
    assign unused_campos = ^{bus.instrucao[24:15], bus.instrucao[11:7], BITS[0]};

    assign espera_prox = espera + 8'd1;

    // Decode the latched fields into an instruction class.
    always_comb begin
        classe = C_ILEGAL;
        case (opcode)
            OP_R: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    classe = C_ADD;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    classe = C_SUB;
                end
            end
            OP_I: begin
                if (funct3 == 3'b000) classe = C_ADDI;
            end
            OP_LOAD: begin
                if (funct3 == 3'b011) classe = C_LD;
            end
            OP_STORE: begin
                if (funct3 == 3'b011) classe = C_SD;
            end
            OP_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) classe = C_BR;
            end
            default: classe = C_ILEGAL;
        endcase
    end

    // Branch condition from funct3 and the ULA flags (rs1 vs rs2).
    always_comb begin
        tomado = 1'b0;
        case (funct3)
            3'b000:  tomado = bus.flag_igual;
            3'b001:  tomado = !bus.flag_igual;
            3'b100:  tomado = bus.flag_menor;
            3'b101:  tomado = !bus.flag_menor;
            3'b110:  tomado = !bus.flag_maior_igual_u;
            3'b111:  tomado = bus.flag_maior_igual_u;
            default: tomado = 1'b0;
        endcase
    end

    // Control FSM: state, latched instruction fields and memory wait counter.
    // The counter is cleared on every entry to BUSCA or MEMORIA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= INICIO;
            opcode <= 7'd0;
            funct3 <= 3'd0;
            funct7 <= 7'd0;
            espera <= 8'd0;
        end else begin
            case (estado)
                INICIO: begin
                    estado <= BUSCA;
                    espera <= 8'd0;
                end
                BUSCA: begin
                    if (bus.mem_pronta) begin
                        opcode <= bus.instrucao[6:0];
                        funct3 <= bus.instrucao[14:12];
                        funct7 <= bus.instrucao[31:25];
                        estado <= DECODIFICA;
                    end else begin
                        espera <= espera_prox;
                        if (espera_prox == LIMITE) estado <= ERRO;
                    end
                end
                DECODIFICA: begin
                    estado <= (classe == C_ILEGAL) ? ERRO : EXECUTA;
                end
                EXECUTA: begin
                    espera <= 8'd0;
                    case (classe)
                        C_ADD, C_SUB, C_ADDI: estado <= ESCRITA;
                        C_LD, C_SD:           estado <= MEMORIA;
                        C_BR:                 estado <= BUSCA;
                        default:              estado <= ERRO;
                    endcase
                end
                MEMORIA: begin
                    if (bus.mem_pronta) begin
                        espera <= 8'd0;
                        estado <= (classe == C_LD) ? ESCRITA : BUSCA;
                    end else begin
                        espera <= espera_prox;
                        if (espera_prox == LIMITE) estado <= ERRO;
                    end
                end
                ESCRITA: begin
                    espera <= 8'd0;
                    estado <= BUSCA;
                end
                ERRO: begin
                    estado <= ERRO;
                end
                default: begin
                    estado <= ERRO;
                end
            endcase
        end
    end

    logic [1:0] soma_ou_subtrai;
    logic       usa_imm;
    logic       mem_le;
    logic       mem_escreve;
    logic       end_pc;
    logic       escreve_ri;
    logic       escreve_reg;
    logic       sel_mem;
    logic       carrega_pc;
    logic       desvio;
    logic       erro;

    // Control outputs decoded from state, latched fields and mem_pronta, so
    // an asynchronous reset drops every request without waiting for a clock.
    always_comb begin
        soma_ou_subtrai = 2'd0;
        usa_imm         = 1'b0;
        mem_le          = 1'b0;
        mem_escreve     = 1'b0;
        end_pc          = 1'b0;
        escreve_ri      = 1'b0;
        escreve_reg     = 1'b0;
        sel_mem         = 1'b0;
        carrega_pc      = 1'b0;
        desvio          = 1'b0;
        erro            = 1'b0;
        case (estado)
            BUSCA: begin
                mem_le     = 1'b1;
                end_pc     = 1'b1;
                escreve_ri = bus.mem_pronta;
            end
            EXECUTA: begin
                case (classe)
                    C_ADD: soma_ou_subtrai = 2'd1;
                    C_SUB: soma_ou_subtrai = 2'd2;
                    C_ADDI, C_LD, C_SD: begin
                        soma_ou_subtrai = 2'd1;
                        usa_imm         = 1'b1;
                    end
                    C_BR: begin
                        carrega_pc = 1'b1;
                        desvio     = tomado;
                    end
                    default: ;
                endcase
            end
            MEMORIA: begin
                // Address computation is held so the address stays stable.
                soma_ou_subtrai = 2'd1;
                usa_imm         = 1'b1;
                if (classe == C_LD) begin
                    mem_le = 1'b1;
                end else begin
                    mem_escreve = 1'b1;
                    carrega_pc  = bus.mem_pronta;
                end
            end
            ESCRITA: begin
                escreve_reg = 1'b1;
                carrega_pc  = 1'b1;
                case (classe)
                    C_ADD: soma_ou_subtrai = 2'd1;
                    C_SUB: soma_ou_subtrai = 2'd2;
                    C_ADDI: begin
                        soma_ou_subtrai = 2'd1;
                        usa_imm         = 1'b1;
                    end
                    C_LD: sel_mem = 1'b1;
                    default: ;
                endcase
            end
            ERRO: begin
                erro = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.soma_ou_subtrai = soma_ou_subtrai;
    assign bus.usa_imm         = usa_imm;
    assign bus.mem_le          = mem_le;
    assign bus.mem_escreve     = mem_escreve;
    assign bus.end_pc          = end_pc;
    assign bus.escreve_ri      = escreve_ri;
    assign bus.escreve_reg     = escreve_reg;
    assign bus.sel_mem         = sel_mem;
    assign bus.carrega_pc      = carrega_pc;
    assign bus.desvio          = desvio;
    assign bus.erro            = erro;
    assign bus.estado          = estado;

endmodule
